sync_fifo: RTL and testbench

- Single-clock synchronous first-in/first-out buffer with registered read data and full/empty status flags.
- Decouples a producer and a consumer in the same clock domain.
- Writes are strobed by data_inen and reads by data_outen.
- Overflow writes and underflow reads are silently ignored.

---
 rtl/sync_fifo.sv | 75 +++++++
 tb/tb_sync_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Overflow writes and underflow reads are dropped without side effects.
module sync_fifo #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned FIFO_SIZE = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 data_inen,
    input  logic                 data_outen,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 fifo_empty,
    output logic                 fifo_full
);

    localparam int unsigned PtrW = $clog2(FIFO_SIZE);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_SIZE-1:0] mem_q [FIFO_SIZE];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;
    logic                 wr_acc, rd_acc;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(FIFO_SIZE));
    assign data_out   = data_out_q;

    // Full gates the write even when a read frees a slot on the same edge.
    assign wr_acc = data_inen & ~fifo_full;
    assign rd_acc = data_outen & ~fifo_empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + PtrW'(1);
            data_out_d = mem_q[rd_ptr_q];
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is not reset; only written words are ever read.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a queue model of FIFO contents plus a
// scoreboard of expected read data, compared after each clock edge.
module tb_sync_fifo;

    localparam int unsigned DATA_SIZE = 8;
    localparam int          FIFO_SIZE = 16;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 data_inen = 1'b0;
    logic                 data_outen = 1'b0;
    logic [DATA_SIZE-1:0] data_in = '0;
    logic [DATA_SIZE-1:0] data_out;
    logic                 fifo_empty;
    logic                 fifo_full;

    int vectors = 0;
    int errors  = 0;

    logic [DATA_SIZE-1:0] model[$];
    logic [DATA_SIZE-1:0] exp_q[$];
    logic [DATA_SIZE-1:0] exp_out = '0;

    sync_fifo #(.DATA_SIZE(DATA_SIZE), .FIFO_SIZE(FIFO_SIZE)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_inen  (data_inen),
        .data_outen (data_outen),
        .data_in    (data_in),
        .data_out   (data_out),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full)
    );

    always #5 clock = ~clock;

    // Apply one edge of stimulus, then advance the model and scoreboard.
    task automatic drive(input logic wen, input logic ren, input logic [DATA_SIZE-1:0] din);
        logic acc_w, acc_r;
        acc_w      = wen && (model.size() < FIFO_SIZE);
        acc_r      = ren && (model.size() != 0);
        data_inen  = wen;
        data_outen = ren;
        data_in    = din;
        @(posedge clock);
        #1;
        if (acc_r) exp_q.push_back(model.pop_front());
        if (acc_w) model.push_back(din);
        data_inen  = 1'b0;
        data_outen = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        vectors++;
        if (data_out !== 8'h00 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_init got out=%h e=%b f=%b want 00 1 0", data_out, fifo_empty,
                     fifo_full);
        end
        reset = 1'b0;
        drive(1'b1, 1'b0, 8'hA5);
        drive(1'b1, 1'b0, 8'h3C);
        drive(1'b0, 1'b1, 8'h00);
        exp_out = exp_q.pop_front();
        vectors++;
        if (data_out !== 8'hA5) begin
            errors++;
            $display("FAIL reset_pre_data got %h want a5", data_out);
        end
        // Async reset mid-cycle with random enables.
        data_inen  = 1'($urandom_range(0, 1));
        data_outen = 1'($urandom_range(0, 1));
        data_in    = 8'($urandom);
        #2;
        reset = 1'b1;
        #1;
        model.delete();
        exp_q.delete();
        exp_out = '0;
        vectors++;
        if (data_out !== 8'h00 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got out=%h e=%b f=%b want 00 1 0", data_out, fifo_empty,
                     fifo_full);
        end
        @(posedge clock);
        #1;
        reset      = 1'b0;
        data_inen  = 1'b0;
        data_outen = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if (data_out !== 8'h00 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got out=%h e=%b f=%b want 00 1 0", data_out, fifo_empty,
                     fifo_full);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 1'b0, 8'hF0);
        vectors++;
        if (fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL single_wr_empty got %b want 0", fifo_empty);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            if (exp_q.size() != 0) exp_out = exp_q.pop_front();
            vectors++;
            if (data_out !== exp_out || exp_out !== 8'hF0) begin
                errors++;
                $display("FAIL single_rd%0d got %h want f0", i, data_out);
            end
            vectors++;
            if (fifo_empty !== 1'b1) begin
                errors++;
                $display("FAIL single_rd%0d_empty got %b want 1", i, fifo_empty);
            end
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 18; i++) begin
            drive(1'b1, 1'b0, 8'(i));
            vectors++;
            if (fifo_full !== (model.size() == FIFO_SIZE) || fifo_full !== (i >= 16)) begin
                errors++;
                $display("FAIL fill%0d_full got %b want %b", i, fifo_full, i >= 16);
            end
            vectors++;
            if (fifo_empty !== 1'b0 || data_out !== exp_out) begin
                errors++;
                $display("FAIL fill%0d got e=%b out=%h want 0 %h", i, fifo_empty, data_out,
                         exp_out);
            end
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 17; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            if (exp_q.size() != 0) exp_out = exp_q.pop_front();
            vectors++;
            if (data_out !== exp_out || data_out !== 8'((i > 16) ? 16 : i)) begin
                errors++;
                $display("FAIL drain%0d_data got %h want %h", i, data_out, exp_out);
            end
            vectors++;
            if (fifo_empty !== (i >= 16) || fifo_full !== 1'b0) begin
                errors++;
                $display("FAIL drain%0d_flags got e=%b f=%b want %b 0", i, fifo_empty, fifo_full,
                         i >= 16);
            end
        end
    endtask

    task automatic test_wrap();
        logic [DATA_SIZE-1:0] v;
        int                   n;
        v = 8'h20;
        for (int pass = 0; pass < 2; pass++) begin
            n = (pass == 0) ? 10 : 12;
            for (int i = 0; i < n; i++) begin
                drive(1'b1, 1'b0, v);
                v = v + 8'h01;
                vectors++;
                if (fifo_empty !== 1'b0 || fifo_full !== 1'b0 || data_out !== exp_out) begin
                    errors++;
                    $display("FAIL wrap_wr%0d_%0d got e=%b f=%b out=%h want 0 0 %h", pass, i,
                             fifo_empty, fifo_full, data_out, exp_out);
                end
            end
            for (int i = 0; i < n; i++) begin
                drive(1'b0, 1'b1, 8'h00);
                if (exp_q.size() != 0) exp_out = exp_q.pop_front();
                vectors++;
                if (data_out !== exp_out) begin
                    errors++;
                    $display("FAIL wrap_rd%0d_%0d got %h want %h", pass, i, data_out, exp_out);
                end
                vectors++;
                if (fifo_empty !== (model.size() == 0) || fifo_full !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_rd%0d_%0d_flags got e=%b f=%b want %b 0", pass, i,
                             fifo_empty, fifo_full, model.size() == 0);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        // Empty: write only.
        drive(1'b1, 1'b1, 8'h55);
        vectors++;
        if (fifo_empty !== 1'b0 || data_out !== exp_out || exp_q.size() != 0
            || model.size() != 1) begin
            errors++;
            $display("FAIL simul_empty got e=%b out=%h want 0 %h", fifo_empty, data_out, exp_out);
        end
        drive(1'b0, 1'b1, 8'h00);
        if (exp_q.size() != 0) exp_out = exp_q.pop_front();
        vectors++;
        if (data_out !== 8'h55 || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL simul_empty_rd got out=%h e=%b want 55 1", data_out, fifo_empty);
        end
        // Full: read only, count drops to 15.
        for (int i = 0; i < FIFO_SIZE; i++) drive(1'b1, 1'b0, 8'h60 + 8'(i));
        drive(1'b1, 1'b1, 8'hEE);
        if (exp_q.size() != 0) exp_out = exp_q.pop_front();
        vectors++;
        if (data_out !== 8'h60 || fifo_full !== 1'b0 || model.size() != FIFO_SIZE - 1) begin
            errors++;
            $display("FAIL simul_full got out=%h f=%b want 60 0", data_out, fifo_full);
        end
        drive(1'b1, 1'b0, 8'h70);
        vectors++;
        if (fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL simul_full_refill got f=%b want 1", fifo_full);
        end
        for (int i = 0; i < FIFO_SIZE; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            if (exp_q.size() != 0) exp_out = exp_q.pop_front();
            vectors++;
            if (data_out !== exp_out) begin
                errors++;
                $display("FAIL simul_full_drain%0d got %h want %h", i, data_out, exp_out);
            end
        end
        // Half full: both accepted each edge, occupancy steady at 8.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'h80 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 8'h90 + 8'(i));
            if (exp_q.size() != 0) exp_out = exp_q.pop_front();
            vectors++;
            if (data_out !== exp_out || fifo_empty !== 1'b0 || fifo_full !== 1'b0) begin
                errors++;
                $display("FAIL simul_half%0d got out=%h e=%b f=%b want %h 0 0", i, data_out,
                         fifo_empty, fifo_full, exp_out);
            end
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            if (exp_q.size() != 0) exp_out = exp_q.pop_front();
            vectors++;
            if (data_out !== exp_out || fifo_empty !== (i == 7)) begin
                errors++;
                $display("FAIL simul_half_drain%0d got out=%h e=%b want %h %b", i, data_out,
                         fifo_empty, exp_out, i == 7);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_drain();
        test_wrap();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
